// File: rtl/mlp_pkg.sv
// Shared constants for the MLP datapath so the multiplier and accumulator agree on width.
package mlp_pkg;

  localparam int DATA_W = 16;

endpackage : mlp_pkg

// File: rtl/csa_fa.sv
// One-bit full adder cell used by the carry-save array and its final ripple row.
module csa_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : csa_fa

// File: rtl/csam.sv
// Unsigned carry-save array multiplier; registers the low WIDTH bits of X*Y each cycle.
module csam
  import mlp_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] answer
);

  // s_v[i]/c_v[i]: sum and carry vectors leaving row i, indexed by product bit weight.
  // Only weights below WIDTH are built; everything at or above WIDTH is dropped.
  logic [WIDTH-1:0] s_v [WIDTH];
  logic [WIDTH-1:0] c_v [WIDTH];
  logic [WIDTH-1:0] rc;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] answer_d;
  logic [WIDTH-1:0] answer_q;

  // Row 0 seeds the array with the first partial-product row.
  assign s_v[0] = X & {WIDTH{Y[0]}};
  assign c_v[0] = '0;

  for (genvar i = 1; i < WIDTH; i++) begin : g_row
    assign c_v[i][0] = 1'b0;
    for (genvar k = 0; k < WIDTH; k++) begin : g_col
      logic pp;
      if (k >= i) begin : g_pp
        assign pp = X[k-i] & Y[i];
      end else begin : g_nopp
        assign pp = 1'b0;
      end
      // Carry moves diagonally: out of column k here, into column k+1 on the next row.
      if (k == WIDTH-1) begin : g_msb
        logic msb_cout_unused;
        csa_fa u_fa (.a(pp), .b(s_v[i-1][k]), .cin(c_v[i-1][k]),
                     .s(s_v[i][k]), .cout(msb_cout_unused));
      end else begin : g_mid
        csa_fa u_fa (.a(pp), .b(s_v[i-1][k]), .cin(c_v[i-1][k]),
                     .s(s_v[i][k]), .cout(c_v[i][k+1]));
      end
    end
  end

  // Final ripple row merges the remaining sum and carry vectors.
  assign rc[0] = 1'b0;
  for (genvar k = 0; k < WIDTH; k++) begin : g_rca
    if (k == WIDTH-1) begin : g_msb
      logic rca_cout_unused;
      csa_fa u_fa (.a(s_v[WIDTH-1][k]), .b(c_v[WIDTH-1][k]), .cin(rc[k]),
                   .s(prod[k]), .cout(rca_cout_unused));
    end else begin : g_mid
      csa_fa u_fa (.a(s_v[WIDTH-1][k]), .b(c_v[WIDTH-1][k]), .cin(rc[k]),
                   .s(prod[k]), .cout(rc[k+1]));
    end
  end

  always_comb begin
    answer_d = prod;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      answer_q <= '0;
    end else begin
      answer_q <= answer_d;
    end
  end

  assign answer = answer_q;

endmodule : csam

// File: tb/tb_csam.sv
// Directed-table, reset-sequence and random checks for the csam multiplier.
module tb_csam;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic [W-1:0] answer;

  int n_pass;
  int n_total;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs [12];

  csam #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .X      (X),
    .Y      (Y),
    .answer (answer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    X = x;
    Y = y;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] rx, ry, rexp;
    logic [2*W-1:0] full;

    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    X       = 16'h1234;
    Y       = 16'h5678;

    vecs[0]  = '{16'h0003, 16'h0005, 16'h000F};
    vecs[1]  = '{16'h00FF, 16'h0101, 16'hFFFF};
    vecs[2]  = '{16'h0000, 16'h1234, 16'h0000};
    vecs[3]  = '{16'h0001, 16'hBEEF, 16'hBEEF};
    vecs[4]  = '{16'hBEEF, 16'h0001, 16'hBEEF};
    vecs[5]  = '{16'h0100, 16'h0100, 16'h0000};
    vecs[6]  = '{16'hFFFF, 16'hFFFF, 16'h0001};
    vecs[7]  = '{16'hFFFF, 16'h0002, 16'hFFFE};
    vecs[8]  = '{16'h0003, 16'h0005, 16'h000F};
    vecs[9]  = '{16'h0007, 16'h0009, 16'h003F};
    vecs[10] = '{16'h1234, 16'h0010, 16'h2340};
    vecs[11] = '{16'h8001, 16'h8001, 16'h0001};

    // Reset state: held at zero across clock edges with operands present.
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", answer, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;

    // Consecutive table entries land on consecutive edges, so 8..10 form the back-to-back run.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].x, vecs[i].y);
      check($sformatf("vec%0d", i), answer, vecs[i].exp);
    end

    // Asynchronous reset asserted between edges.
    drive(16'h00FF, 16'h0101);
    check("pre_reset", answer, 16'hFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", answer, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", answer, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_release", answer, 16'hFFFF);

    // Random operands, one new pair per edge.
    for (int i = 0; i < 10000; i++) begin
      rx   = W'($urandom);
      ry   = W'($urandom);
      full = {16'h0000, rx} * {16'h0000, ry};
      rexp = full[W-1:0];
      drive(rx, ry);
      check("random", answer, rexp);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_csam
